// File: rtl/serv_fetch.sv
// serv_fetch: instruction fetch unit for a bit-serial core.
// The next PC arrives one bit per cycle into a shadow register. A fetch request
// copies it to the bus address and runs a single request/acknowledge bus cycle.
// The fetched word is then handed to the decoder with a one-cycle strobe.
module serv_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        i_rst,
    input  logic        i_pc_en,
    input  logic        i_pc_bit,
    input  logic        i_fetch_req,
    output logic [31:0] o_ibus_adr,
    output logic        o_ibus_cyc,
    input  logic        i_ibus_ack,
    input  logic [31:0] i_ibus_rdt,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_en,
    output logic        o_busy,
    output logic        o_req_overrun
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_FETCH   = 2'd1;
    localparam logic [1:0] S_DELIVER = 2'd2;

    logic [1:0]  state_q,   state_d;
    logic [31:0] shadow_q,  shadow_d;
    logic [31:0] adr_q,     adr_d;
    logic [31:0] rdt_q,     rdt_d;
    logic        cyc_q,     cyc_d;
    logic        wb_en_q,   wb_en_d;
    logic        overrun_q, overrun_d;

    // Shadow PC: shift right with the new bit entering at the top, in every state.
    // Exactly 32 bits arrive per update, so no bit count is needed.
    always_comb begin
        shadow_d = shadow_q;
        if (i_pc_en) begin
            shadow_d = {i_pc_bit, shadow_q[31:1]};
        end
    end

    // Fetch sequencing: IDLE -> FETCH (bus cycle) -> DELIVER (strobe) -> IDLE.
    // The address is taken from the shadow value before this cycle's shift.
    always_comb begin
        state_d = state_q;
        adr_d   = adr_q;
        rdt_d   = rdt_q;
        cyc_d   = cyc_q;
        wb_en_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_fetch_req) begin
                    adr_d   = shadow_q;
                    cyc_d   = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (i_ibus_ack) begin
                    rdt_d   = i_ibus_rdt;
                    cyc_d   = 1'b0;
                    wb_en_d = 1'b1;
                    state_d = S_DELIVER;
                end
            end
            S_DELIVER: begin
                state_d = S_IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // Overrun: a request that arrives while busy is dropped and remembered until reset.
    always_comb begin
        overrun_d = overrun_q | (i_fetch_req & (state_q != S_IDLE));
    end

    // State registers; reset starts the boot fetch from RESET_PC immediately.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q   <= S_FETCH;
            shadow_q  <= RESET_PC;
            adr_q     <= RESET_PC;
            rdt_q     <= 32'h0000_0000;
            cyc_q     <= 1'b1;
            wb_en_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            shadow_q  <= shadow_d;
            adr_q     <= adr_d;
            rdt_q     <= rdt_d;
            cyc_q     <= cyc_d;
            wb_en_q   <= wb_en_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_ibus_adr    = adr_q;
    assign o_ibus_cyc    = cyc_q;
    assign o_wb_rdt      = rdt_q;
    // A reset landing in the deliver cycle withholds the strobe from the decoder.
    assign o_wb_en       = wb_en_q & ~i_rst;
    assign o_busy        = (state_q != S_IDLE);
    assign o_req_overrun = overrun_q;

endmodule

// File: tb/tb_serv_fetch.sv
// Directed bench for serv_fetch: boot fetch, serial PC load, overlapping
// request, zero-wait ack, spurious ack and reset during an ack.
module tb_serv_fetch;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_pc_en = 1'b0;
    logic        i_pc_bit = 1'b0;
    logic        i_fetch_req = 1'b0;
    logic [31:0] o_ibus_adr;
    logic        o_ibus_cyc;
    logic        i_ibus_ack = 1'b0;
    logic [31:0] i_ibus_rdt = 32'h0;
    logic [31:0] o_wb_rdt;
    logic        o_wb_en;
    logic        o_busy;
    logic        o_req_overrun;

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_adr_q[$];

    serv_fetch #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .i_rst(i_rst), .i_pc_en(i_pc_en), .i_pc_bit(i_pc_bit),
        .i_fetch_req(i_fetch_req), .o_ibus_adr(o_ibus_adr), .o_ibus_cyc(o_ibus_cyc),
        .i_ibus_ack(i_ibus_ack), .i_ibus_rdt(i_ibus_rdt), .o_wb_rdt(o_wb_rdt),
        .o_wb_en(o_wb_en), .o_busy(o_busy), .o_req_overrun(o_req_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic shift_pc(input logic [31:0] v);
        for (int i = 0; i < 32; i++) begin
            i_pc_en  = 1'b1;
            i_pc_bit = v[i];
            tick();
        end
        i_pc_en  = 1'b0;
        i_pc_bit = 1'b0;
    endtask

    task automatic request(input logic [31:0] adr);
        exp_adr_q.push_back(adr);
        i_fetch_req = 1'b1;
        tick();
        i_fetch_req = 0;
    endtask

    // Serve the outstanding bus cycle: check address, wait, ack, then check delivery.
    task automatic serve(input int delay, input logic [31:0] rdt);
        logic [31:0] exp_adr;
        int n = 0;
        while (!o_ibus_cyc && n < 20) begin
            tick();
            n++;
        end
        chk("cyc_seen", {31'b0, o_ibus_cyc}, 32'd1);
        if (exp_adr_q.size() == 0) begin
            chk("queue_nonempty", 32'd0, 32'd1);
            exp_adr = 32'hxxxx_xxxx;
        end else begin
            exp_adr = exp_adr_q.pop_front();
        end
        chk("ibus_adr", o_ibus_adr, exp_adr);
        for (int i = 0; i < delay; i++) begin
            chk("cyc_wait", {31'b0, o_ibus_cyc}, 32'd1);
            chk("wb_en_wait", {31'b0, o_wb_en}, 32'd0);
            tick();
        end
        chk("adr_stable", o_ibus_adr, exp_adr);
        i_ibus_ack = 1'b1;
        i_ibus_rdt = rdt;
        tick();
        i_ibus_ack = 1'b0;
        i_ibus_rdt = 32'h0;
        chk("wb_en_pulse", {31'b0, o_wb_en}, 32'd1);
        chk("wb_rdt", o_wb_rdt, rdt);
        chk("cyc_drop", {31'b0, o_ibus_cyc}, 32'd0);
        tick();
        chk("wb_en_single", {31'b0, o_wb_en}, 32'd0);
        chk("idle_after", {31'b0, o_busy}, 32'd0);
        chk("wb_rdt_hold", o_wb_rdt, rdt);
        $display("txn adr=%h rdt=%h delay=%0d", exp_adr, rdt, delay);
    endtask

    initial begin
        // Reset state and boot fetch
        tick();
        tick();
        chk("rst_adr", o_ibus_adr, RST_PC);
        chk("rst_cyc", {31'b0, o_ibus_cyc}, 32'd1);
        chk("rst_wb_rdt", o_wb_rdt, 32'h0);
        chk("rst_wb_en", {31'b0, o_wb_en}, 32'd0);
        chk("rst_overrun", {31'b0, o_req_overrun}, 32'd0);
        exp_adr_q.push_back(RST_PC);
        i_rst = 1'b0;
        serve(2, 32'h0000_0013);

        // Serial PC load then request
        shift_pc(32'h0000_0104);
        request(32'h0000_0104);
        chk("req_cyc", {31'b0, o_ibus_cyc}, 32'd1);
        chk("req_adr", o_ibus_adr, 32'h0000_0104);

        // Overlapping shift and request during FETCH
        shift_pc(32'h0000_0200);
        i_fetch_req = 1'b1;
        tick();
        i_fetch_req = 1'b0;
        chk("ovl_adr", o_ibus_adr, 32'h0000_0104);
        chk("ovl_overrun", {31'b0, o_req_overrun}, 32'd1);
        serve(1, 32'hCAFE_0001);

        // Zero-wait fetch of the shifted 0x200
        request(32'h0000_0200);
        serve(0, 32'hDEAD_BEEF);
        chk("overrun_sticky", {31'b0, o_req_overrun}, 32'd1);

        // Spurious ack in IDLE
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'h1234_5678;
        tick();
        i_ibus_ack = 1'b0;
        i_ibus_rdt = 32'h0;
        chk("spur_rdt", o_wb_rdt, 32'hDEAD_BEEF);
        chk("spur_wb_en", {31'b0, o_wb_en}, 32'd0);
        chk("spur_busy", {31'b0, o_busy}, 32'd0);
        tick();
        chk("spur_wb_en2", {31'b0, o_wb_en}, 32'd0);
        $display("txn spurious ack rdt=12345678 ignored");

        // Reset in the ack cycle of a fetch of 0x300
        shift_pc(32'h0000_0300);
        request(32'h0000_0300);
        chk("f300_adr", o_ibus_adr, exp_adr_q.pop_front());
        i_ibus_ack = 1'b1;
        i_ibus_rdt = 32'h5555_AAAA;
        i_rst = 1'b1;
        tick();
        i_ibus_ack = 1'b0;
        chk("rst_ack_wb_en", {31'b0, o_wb_en}, 32'd0);
        chk("rst_ack_adr", o_ibus_adr, RST_PC);
        chk("rst_ack_overrun", {31'b0, o_req_overrun}, 32'd0);
        chk("rst_ack_rdt", o_wb_rdt, 32'h0);
        i_rst = 1'b0;
        exp_adr_q.push_back(RST_PC);
        serve(1, 32'h0000_0093);
        $display("txn reset during ack of 300 restarted at %h", RST_PC);

        // Shadow was reloaded by reset, so an unshifted request fetches RESET_PC
        request(RST_PC);
        serve(0, 32'h0000_0073);

        chk("queue_empty", exp_adr_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serv_fetch.md
SERV_FETCH -- requirements
Module: serv_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first instruction fetched after reset.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port i_pc_en  input  1  PC serial bit valid this cycle.
REQ-005 SHALL have port i_pc_bit  input  1  next-PC bit, LSB first.
REQ-006 SHALL have port i_fetch_req  input  1  single-cycle pulse: next PC complete, fetch it.
REQ-007 SHALL have port o_ibus_adr  output  32  instruction bus address.
REQ-008 SHALL have port o_ibus_cyc  output  1  instruction bus request, held until ack.
REQ-009 SHALL have port i_ibus_ack  input  1  instruction bus acknowledge, data valid same cycle.
REQ-010 SHALL have port i_ibus_rdt  input  32  instruction bus read data.
REQ-011 SHALL have port o_wb_rdt  output  32  captured instruction word to decoder.
REQ-012 SHALL have port o_wb_en  output  1  one-cycle instruction-valid strobe to decoder.
REQ-013 SHALL have port o_busy  output  1  high while in FETCH or DELIVER.
REQ-014 SHALL have port o_req_overrun  output  1  sticky error flag: request received while busy.

Function
REQ-015 SHALL implement a 3-state machine: IDLE, FETCH, DELIVER.
REQ-016 SHALL keep a 32-bit shadow PC register; on each cycle with i_pc_en=1 it shifts right one place, with i_pc_bit entering bit 31.
REQ-017 After 32 enabled shifts, the first serial bit SHALL sit in bit 0; no bit counter is kept, because the core guarantees exactly 32 bits per update.
REQ-018 Shadow shifting SHALL occur in every state; it SHALL never alter o_ibus_adr during FETCH.
REQ-019 IDLE + i_fetch_req=1: SHALL load o_ibus_adr from the shadow register, with a same-cycle i_pc_en shift excluded, and go to FETCH next cycle.
REQ-020 FETCH: o_ibus_cyc SHALL be 1, and o_ibus_adr SHALL be stable.
REQ-021 FETCH + i_ibus_ack=1: SHALL capture i_ibus_rdt into o_wb_rdt, go to DELIVER, and drop o_ibus_cyc on the next cycle.
REQ-022 o_ibus_cyc SHALL be registered: it is deasserted in the cycle after ack, so exactly one cycle of cyc&ack occurs per fetch.
REQ-023 FETCH with no ack SHALL wait indefinitely, with no timeout.
REQ-024 DELIVER: o_wb_en SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-025 Minimum latency SHALL be 3 cycles: req at cycle N, cyc at N+1, ack at N+1, wb_en at N+2, IDLE at N+3.
REQ-026 o_wb_rdt SHALL hold its value until the next ack and SHALL NOT be cleared by wb_en.
REQ-027 i_fetch_req in FETCH or DELIVER SHALL be ignored (no queuing) and SHALL set o_req_overrun, which stays set until reset.
REQ-028 i_ibus_ack outside FETCH SHALL be ignored: no capture and no state change.
REQ-029 o_ibus_adr[1:0] SHALL be driven as loaded; alignment is the core's responsibility.
REQ-030 o_busy SHALL equal (state != IDLE).

Reset
REQ-031 i_rst=1 SHALL force, on the next edge: shadow PC = RESET_PC, o_ibus_adr = RESET_PC, o_wb_rdt = 0, o_wb_en = 0, o_req_overrun = 0, state = FETCH, o_ibus_cyc = 1.
REQ-032 The boot fetch SHALL therefore start in the first cycle after reset with no i_fetch_req.
REQ-033 Reset SHALL take priority over all other inputs, including ack, req and pc_en in the same cycle.
REQ-034 Reset mid-FETCH SHALL restart the fetch from RESET_PC; an ack arriving in the reset cycle SHALL be discarded.
REQ-035 Reset mid-DELIVER SHALL suppress the pending o_wb_en pulse.

Verification
REQ-036 Boot: RESET_PC=32'h0000_0100; release reset; ack after 2 cycles with rdt=32'h0000_0013 -> adr=0x100; cyc high for 3 cycles; wb_rdt=0x13; one wb_en pulse.
REQ-037 Serial PC: shift 0x0000_0104 LSB-first over 32 pc_en cycles, then pulse req -> next cycle cyc=1 and adr=0x104.
REQ-038 Overlap: during FETCH of 0x104, shift 0x0000_0200 and pulse req -> adr stays 0x104, overrun=1; a later req from IDLE fetches 0x200.
REQ-039 Zero-wait: ack asserted in the first FETCH cycle, rdt=32'hDEAD_BEEF -> wb_en exactly 2 cycles after req; no second cyc&ack cycle.
REQ-040 Spurious ack in IDLE with rdt=0x1234_5678 -> wb_rdt unchanged, no wb_en, state IDLE.
REQ-041 Reset asserted in the ack cycle of a fetch of 0x300 -> no wb_en; fetch restarts at RESET_PC; overrun=0.
